// File: rtl/mux_rr_sched_if.sv
// mux_rr_sched_if: request/grant bundle between the requesters and the round-robin mux scheduler
interface mux_rr_sched_if #(parameter int n = 2);
  logic [2**n-1:0] req;
  logic done;
  logic [n-1:0] sel;
  logic [2**n-1:0] gnt;
  logic busy;
  logic preempt;
  modport master(output req, done, input sel, gnt, busy, preempt);
  modport slave(input req, done, output sel, gnt, busy, preempt);
endinterface

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin owner of a shared 2**n:1 mux with done/drop/hold-limit release
module mux_rr_sched #(
  parameter int n = 2,
  parameter int HOLD_MAX = 8
) (
  input logic clk,
  input logic rst_n,
  mux_rr_sched_if.slave bus
);
  localparam int NREQ = 2**n;
  localparam int CW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_d;
  logic [n-1:0] sel, sel_d, win, idx;
  logic [CW-1:0] cnt, cnt_d;
  logic pre, pre_d, hit, rel;
  // search starts just after the last winner and ends on it, so it is regranted only when alone
  always_comb begin
    win = sel;
    hit = 1'b0;
    idx = sel;
    for (int i = 1; i <= NREQ; i++) begin
      idx = sel + n'(i);
      if (!hit && bus.req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state;
    sel_d = sel;
    cnt_d = cnt;
    pre_d = 1'b0;
    rel = bus.done | ~bus.req[sel] | (cnt == CW'(HOLD_MAX - 1));
    if (state == IDLE || rel) begin
      pre_d = (state == GRANT) & ~bus.done & bus.req[sel];
      state_d = hit ? GRANT : IDLE;
      sel_d = win;
      cnt_d = '0;
    end else cnt_d = cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= '1;
      cnt <= '0;
      pre <= 1'b0;
    end else begin
      state <= state_d;
      sel <= sel_d;
      cnt <= cnt_d;
      pre <= pre_d;
    end
  assign bus.sel = sel;
  assign bus.busy = state == GRANT;
  assign bus.gnt = state == GRANT ? NREQ'(1) << sel : '0;
  assign bus.preempt = pre;
endmodule

// File: tb/tb_mux_rr_sched.sv
// tb_mux_rr_sched: three schedulers (HOLD_MAX 8, 4, 1) on shared stimulus, checked against a queue-free rotation model
module tb_mux_rr_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic done = 1'b0;
  logic [2:0][1:0] sel_a;
  logic [2:0][3:0] gnt_a;
  logic [2:0] busy_a, pre_a;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  function automatic int hm(int g);
    return g == 0 ? 8 : g == 1 ? 4 : 1;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int H = (g == 0) ? 8 : (g == 1) ? 4 : 1;
    mux_rr_sched_if #(.n(2)) bus ();
    assign bus.req = req;
    assign bus.done = done;
    mux_rr_sched #(.n(2), .HOLD_MAX(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign sel_a[g] = bus.sel;
    assign gnt_a[g] = bus.gnt;
    assign busy_a[g] = bus.busy;
    assign pre_a[g] = bus.preempt;
  end
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // model: owner index, busy flag, cycles the current grant has been held so far
  int m_sel [3];
  int m_held [3];
  bit m_busy [3];
  bit m_pre [3];
  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        m_sel[g] = 3;
        m_busy[g] = 0;
        m_pre[g] = 0;
        m_held[g] = 0;
      end else begin
        bit rel, tmo;
        int w;
        tmo = m_held[g] == hm(g);
        rel = !m_busy[g] || done || !req[m_sel[g]] || tmo;
        m_pre[g] = m_busy[g] && !done && req[m_sel[g]] && tmo;
        if (!rel) m_held[g]++;
        else if (req == 4'b0) m_busy[g] = 0;
        else begin
          w = -1;
          for (int k = 1; k <= 4; k++)
            if (w < 0 && req[(m_sel[g] + k) % 4]) w = (m_sel[g] + k) % 4;
          m_sel[g] = w;
          m_busy[g] = 1;
          m_held[g] = 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("m%0d_sel", g), sel_a[g], m_sel[g]);
      chk($sformatf("m%0d_busy", g), busy_a[g], m_busy[g]);
      chk($sformatf("m%0d_gnt", g), gnt_a[g], m_busy[g] ? (1 << m_sel[g]) : 0);
      chk($sformatf("m%0d_pre", g), pre_a[g], m_pre[g]);
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask
  initial begin
    req = 4'b1111;
    done = 1'b1;
    step();
    step();
    chk("rst_sel", sel_a[0], 3);
    chk("rst_gnt", gnt_a[0], 0);
    chk("rst_busy", busy_a[0], 0);
    chk("rst_pre", pre_a[0], 0);
    req = 4'b0;
    done = 1'b0;
    rst_n = 1'b1;
    req = 4'b0100;
    step();
    chk("single_gnt", gnt_a[0], 4'b0100);
    chk("single_sel", sel_a[0], 2);
    chk("single_busy", busy_a[0], 1);
    step();
    chk("single_hold", gnt_a[0], 4'b0100);
    done = 1'b1;
    req = 4'b0;
    step();
    chk("single_rel_gnt", gnt_a[0], 0);
    chk("single_rel_busy", busy_a[0], 0);
    chk("single_rel_sel", sel_a[0], 2);
    step();
    pulse_reset();
    req = 4'b1111;
    done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_sel", sel_a[0], i % 4);
      chk("rr_busy", busy_a[0], 1);
    end
    req = 4'b0;
    done = 1'b0;
    step();
    chk("rr_idle", busy_a[0], 0);
    pulse_reset();
    req = 4'b0011;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("tmo_gnt", gnt_a[1], (i <= 4 || i == 9) ? 4'b0001 : 4'b0010);
      chk("tmo_pre", pre_a[1], (i == 5 || i == 9) ? 1 : 0);
      chk("h1_gnt", gnt_a[2], (i % 2 == 1) ? 4'b0001 : 4'b0010);
      chk("h1_pre", pre_a[2], i >= 2 ? 1 : 0);
    end
    req = 4'b1000;
    step();
    chk("sole_first_pre", pre_a[1], 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("sole_gnt", gnt_a[1], 4'b1000);
      chk("sole_sel", sel_a[1], 3);
      chk("sole_pre", pre_a[1], (i % 4 == 0) ? 1 : 0);
    end
    req = 4'b0;
    step();
    pulse_reset();
    req = 4'b0010;
    step();
    chk("ar_pre_gnt", gnt_a[0], 4'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", gnt_a[0], 0);
    chk("ar_busy", busy_a[0], 0);
    chk("ar_sel", sel_a[0], 3);
    req = 4'b0110;
    done = 1'b1;
    #1;
    chk("ar_hold_gnt", gnt_a[0], 0);
    rst_n = 1'b1;
    done = 1'b0;
    step();
    chk("ar_first_gnt", gnt_a[0], 4'b0010);
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
